stack_seq_unit: RTL and testbench



---
 rtl/stack_seq_unit.sv | 234 +++++++++++++++++++++++
 tb/tb_stack_seq_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_seq_unit.sv
// rtl/stack_seq_unit.sv - stack micro-sequencer for interrupt entry, CALL, RET and RETI
//
// Purpose:
//    Owns the multi-cycle stack sequences of the decode stage. While busy is
//    high its strobes override fetch/decode enables and drive the memory-stage
//    stack signals. The trigger cycle is the first step of a sequence, so all
//    outputs decode combinationally from (state, cnt, trigger); state is registered.
//
// Ports:
//    clk, rst_n            clock, asynchronous active-low reset
//    opcode, op_valid      instruction currently in decode
//    interrupt             external interrupt request
//    stall                 hazard hold; freezes the sequencer
//    busy                  sequence in progress (including trigger cycle)
//    fd_enable, pc_enable  fetch/decode buffer and PC update enables
//    jump_sel              00 seq, 01 call target, 10 interrupt vector, 11 popped PC
//    mem_rd, mem_wr, sp_wr stack pop / push / SP update strobes
//    item_idx              0 = flags, k+1 = PC word k
//    wb_flags, wb_pc       write-back of popped flags / PC word
//
// Configuration:
//    STACK_SEQ_INT_LATCH_EN  when defined, an interrupt seen while busy is
//                            latched in pending and serviced at the next IDLE.

module stack_seq_unit #(
   parameter int                PC_WORDS     = 2,
   parameter int                DRAIN_CYCLES = 2,
   parameter int                OP_W         = 6,
   parameter logic [OP_W-1:0]   OP_CALL      = 6'b100101,
   parameter logic [OP_W-1:0]   OP_RET       = 6'b100110,
   parameter logic [OP_W-1:0]   OP_RETI      = 6'b100111,
   localparam int               IW           = $clog2(PC_WORDS + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [OP_W-1:0] opcode,
   input  logic            op_valid,
   input  logic            interrupt,
   input  logic            stall,
   output logic            busy,
   output logic            fd_enable,
   output logic            pc_enable,
   output logic [1:0]      jump_sel,
   output logic            mem_rd,
   output logic            mem_wr,
   output logic            sp_wr,
   output logic [IW-1:0]   item_idx,
   output logic            wb_flags,
   output logic            wb_pc
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PUSH_F,
      S_PUSH_PC,
      S_POP_PC,
      S_POP_F,
      S_DRAIN
   } state_t;

   // cnt only needs to reach 3 since both PC_WORDS and DRAIN_CYCLES are 1..4
   localparam logic [1:0] LAST_PC = 2'(PC_WORDS - 1);
   localparam logic [1:0] LAST_DR = 2'(DRAIN_CYCLES - 1);

   state_t     state_q, state_d, cur_st;
   logic [1:0] cnt_q, cnt_d, cur_cnt;
   // kind distinguishes INT from CALL in PUSH_PC and RETI from RET in POP_PC
   logic       kind_q, kind_d, cur_kind;
   logic       trig_int;
   logic       int_req;

`ifdef STACK_SEQ_INT_LATCH_EN
   logic pending_q, pending_d;
   assign int_req = interrupt | pending_q;
`else
   assign int_req = interrupt;
`endif

   // Effective step for this cycle: in IDLE an accepted trigger becomes step 0
   always_comb begin
      cur_st   = state_q;
      cur_cnt  = cnt_q;
      cur_kind = kind_q;
      trig_int = 1'b0;
      if (state_q == S_IDLE && !stall) begin
         if (int_req) begin
            cur_st   = S_PUSH_F;
            cur_cnt  = 2'd0;
            cur_kind = 1'b1;
            trig_int = 1'b1;
         end else if (op_valid && opcode == OP_RETI) begin
            cur_st   = S_POP_PC;
            cur_cnt  = LAST_PC;
            cur_kind = 1'b1;
         end else if (op_valid && opcode == OP_RET) begin
            cur_st   = S_POP_PC;
            cur_cnt  = LAST_PC;
            cur_kind = 1'b0;
         end else if (op_valid && opcode == OP_CALL) begin
            cur_st   = S_PUSH_PC;
            cur_cnt  = 2'd0;
            cur_kind = 1'b0;
         end
      end
   end

   // Output decode and next-state
   always_comb begin
      busy      = (cur_st != S_IDLE);
      fd_enable = 1'b0;
      pc_enable = 1'b0;
      jump_sel  = 2'b00;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      sp_wr     = 1'b0;
      item_idx  = '0;
      wb_flags  = 1'b0;
      wb_pc     = 1'b0;
      state_d   = cur_st;
      cnt_d     = cur_cnt;
      kind_d    = cur_kind;

      case (cur_st)
         S_IDLE: begin
            fd_enable = 1'b1;
            pc_enable = 1'b1;
         end
         S_PUSH_F: begin
            mem_wr  = 1'b1;
            sp_wr   = 1'b1;
            state_d = S_PUSH_PC;
            cnt_d   = 2'd0;
         end
         S_PUSH_PC: begin
            mem_wr   = 1'b1;
            sp_wr    = 1'b1;
            item_idx = IW'({1'b0, cur_cnt} + 3'd1);
            // INT redirects to the vector on its first PC push
            if (cur_kind && cur_cnt == 2'd0) begin
               pc_enable = 1'b1;
               jump_sel  = 2'b10;
            end
            if (cur_cnt == LAST_PC) begin
               fd_enable = 1'b1;
               if (!cur_kind) begin
                  pc_enable = 1'b1;
                  jump_sel  = 2'b01;
               end
               state_d = S_IDLE;
               cnt_d   = 2'd0;
            end else begin
               cnt_d = cur_cnt + 2'd1;
            end
         end
         S_POP_PC: begin
            mem_rd   = 1'b1;
            sp_wr    = 1'b1;
            wb_pc    = 1'b1;
            item_idx = IW'({1'b0, cur_cnt} + 3'd1);
            if (cur_cnt == 2'd0) begin
               state_d = cur_kind ? S_POP_F : S_DRAIN;
            end else begin
               cnt_d = cur_cnt - 2'd1;
            end
         end
         S_POP_F: begin
            mem_rd   = 1'b1;
            sp_wr    = 1'b1;
            wb_flags = 1'b1;
            state_d  = S_DRAIN;
            cnt_d    = 2'd0;
         end
         S_DRAIN: begin
            if (cur_cnt == LAST_DR) begin
               fd_enable = 1'b1;
               pc_enable = 1'b1;
               jump_sel  = 2'b11;
               state_d   = S_IDLE;
               cnt_d     = 2'd0;
            end else begin
               cnt_d = cur_cnt + 2'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 2'd0;
         end
      endcase

      if (stall) begin
         fd_enable = 1'b0;
         pc_enable = 1'b0;
         mem_rd    = 1'b0;
         mem_wr    = 1'b0;
         sp_wr     = 1'b0;
         wb_flags  = 1'b0;
         wb_pc     = 1'b0;
         state_d   = state_q;
         cnt_d     = cnt_q;
         kind_d    = kind_q;
      end
   end

`ifdef STACK_SEQ_INT_LATCH_EN
   // Entering PUSH_F consumes the request; otherwise any interrupt seen while busy is kept
   always_comb begin
      pending_d = pending_q;
      if (trig_int) begin
         pending_d = 1'b0;
      end else if (busy && interrupt) begin
         pending_d = 1'b1;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= 2'd0;
         kind_q    <= 1'b0;
`ifdef STACK_SEQ_INT_LATCH_EN
         pending_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         kind_q    <= kind_d;
`ifdef STACK_SEQ_INT_LATCH_EN
         pending_q <= pending_d;
`endif
      end
   end

endmodule

// File: tb/tb_stack_seq_unit.sv
// tb/tb_stack_seq_unit.sv - self-checking bench for stack_seq_unit

module tb_stack_seq_unit;

   localparam int PW = 2;
   localparam int DC = 2;
   localparam int IW = $clog2(PW + 1);
   localparam int VW = 10 + IW;
   localparam logic [5:0] OPC_CALL = 6'b100101;
   localparam logic [5:0] OPC_RET  = 6'b100110;
   localparam logic [5:0] OPC_RETI = 6'b100111;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [5:0]    opcode;
   logic          op_valid, interrupt, stall;
   logic          busy, fd_enable, pc_enable, mem_rd, mem_wr, sp_wr, wb_flags, wb_pc;
   logic [1:0]    jump_sel;
   logic [IW-1:0] item_idx;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: a script of expected per-cycle output vectors for the running sequence
   logic [VW-1:0] script[$];
   bit            pend = 1'b0;

   stack_seq_unit #(.PC_WORDS(PW), .DRAIN_CYCLES(DC)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .op_valid(op_valid),
      .interrupt(interrupt), .stall(stall), .busy(busy), .fd_enable(fd_enable),
      .pc_enable(pc_enable), .jump_sel(jump_sel), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .sp_wr(sp_wr), .item_idx(item_idx), .wb_flags(wb_flags), .wb_pc(wb_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [VW-1:0] mk(bit b, bit fd, bit pc, logic [1:0] js, bit rd,
                                        bit wr, bit sp, int idx, bit wf, bit wp);
      return {b, fd, pc, js, rd, wr, sp, IW'(idx), wf, wp};
   endfunction

   function automatic logic [VW-1:0] pack_obs();
      return {busy, fd_enable, pc_enable, jump_sel, mem_rd, mem_wr, sp_wr, item_idx, wb_flags, wb_pc};
   endfunction

   task automatic load_int();
      script.push_back(mk(1, 0, 0, 2'b00, 0, 1, 1, 0, 0, 0));
      for (int k = 0; k < PW; k++)
         script.push_back(mk(1, k == PW-1, k == 0, (k == 0) ? 2'b10 : 2'b00, 0, 1, 1, k+1, 0, 0));
   endtask

   task automatic load_call();
      for (int k = 0; k < PW; k++)
         script.push_back(mk(1, k == PW-1, k == PW-1, (k == PW-1) ? 2'b01 : 2'b00, 0, 1, 1, k+1, 0, 0));
   endtask

   task automatic load_ret(input bit with_flags);
      for (int k = PW-1; k >= 0; k--)
         script.push_back(mk(1, 0, 0, 2'b00, 1, 0, 1, k+1, 0, 1));
      if (with_flags)
         script.push_back(mk(1, 0, 0, 2'b00, 1, 0, 1, 0, 1, 0));
      for (int d = 0; d < DC; d++)
         script.push_back(mk(1, d == DC-1, d == DC-1, (d == DC-1) ? 2'b11 : 2'b00, 0, 0, 0, 0, 0, 0));
   endtask

   // Drives one cycle's inputs at negedge, samples DUT, derives the expected vector, advances at posedge
   task automatic run_cycle(input logic intr, input logic ov, input logic [5:0] op, input logic st,
                            output logic [VW-1:0] obs, output logic [VW-1:0] exp,
                            output logic [VW-1:0] mask);
      bit ld_int;
      bit np;
      @(negedge clk);
      interrupt = intr; op_valid = ov; opcode = op; stall = st;
      #1;
      obs = pack_obs();
      ld_int = 1'b0;
      if (script.size() == 0 && !st) begin
         if (intr || pend) begin load_int(); ld_int = 1'b1; end
         else if (ov && op == OPC_RETI) load_ret(1'b1);
         else if (ov && op == OPC_RET) load_ret(1'b0);
         else if (ov && op == OPC_CALL) load_call();
      end
      mask = '1;
      if (script.size() == 0)
         exp = st ? mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0) : mk(0, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0);
      else if (st) begin
         exp  = mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
         mask = mk(1, 1, 1, 2'b00, 1, 1, 1, 0, 1, 1);
      end else
         exp = script[0];
      np = pend;
`ifdef STACK_SEQ_INT_LATCH_EN
      if (ld_int) np = 1'b0;
      else if (script.size() != 0 && intr) np = 1'b1;
`endif
      @(posedge clk);
      if (!st && script.size() != 0) void'(script.pop_front());
      pend = np;
   endtask

   task automatic test_reset();
      logic [VW-1:0] obs;
      rst_n = 1'b0; interrupt = 0; op_valid = 0; opcode = '0; stall = 0;
      repeat (2) @(posedge clk);
      #1;
      obs = pack_obs();
      vectors++;
      if (obs !== mk(0, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0)) begin
         miscompares++;
         $display("FAIL reset_state: got %b want %b", obs, mk(0, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0));
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset_mid_ret();
      logic [VW-1:0] obs, exp, mask;
      run_cycle(0, 1, OPC_RET, 0, obs, exp, mask);
      vectors++;
      if ((obs & mask) !== (exp & mask)) begin
         miscompares++; $display("FAIL mid_ret c1: got %b want %b", obs, exp);
      end
      run_cycle(0, 0, 6'd0, 0, obs, exp, mask);
      vectors++;
      if ((obs & mask) !== (exp & mask)) begin
         miscompares++; $display("FAIL mid_ret c2: got %b want %b", obs, exp);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      script.delete();
      pend = 1'b0;
      obs = pack_obs();
      vectors++;
      if (obs !== mk(0, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0) || mem_rd !== 1'b0) begin
         miscompares++; $display("FAIL mid_ret_abort: got %b want %b", obs, mk(0, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0));
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         run_cycle(0, 0, 6'd0, 0, obs, exp, mask);
         vectors++;
         if ((obs & mask) !== (exp & mask)) begin
            miscompares++; $display("FAIL mid_ret_after c%0d: got %b want %b", i, obs, exp);
         end
      end
   endtask

   task automatic test_int();
      logic [VW-1:0] obs, exp, mask;
      for (int i = 0; i < 5; i++) begin
         run_cycle(i == 0, 0, 6'd0, 0, obs, exp, mask);
         vectors++;
         if ((obs & mask) !== (exp & mask)) begin
            miscompares++; $display("FAIL int c%0d: got %b want %b", i, obs, exp);
         end
      end
   endtask

   task automatic test_reti();
      logic [VW-1:0] obs, exp, mask;
      for (int i = 0; i < 7; i++) begin
         run_cycle(0, i == 0, OPC_RETI, 0, obs, exp, mask);
         vectors++;
         if ((obs & mask) !== (exp & mask)) begin
            miscompares++; $display("FAIL reti c%0d: got %b want %b", i, obs, exp);
         end
      end
   endtask

   task automatic test_call_stall();
      logic [VW-1:0] obs, exp, mask;
      for (int i = 0; i < 5; i++) begin
         run_cycle(0, i == 0, OPC_CALL, i == 1, obs, exp, mask);
         vectors++;
         if ((obs & mask) !== (exp & mask)) begin
            miscompares++; $display("FAIL call_stall c%0d: got %b want %b", i, obs, exp);
         end
      end
   endtask

   task automatic test_int_during_ret();
      logic [VW-1:0] obs, exp, mask;
      int wr_seen = 0;
      int wr_want;
`ifdef STACK_SEQ_INT_LATCH_EN
      wr_want = 1 + PW;
`else
      wr_want = 0;
`endif
      for (int i = 0; i < 10; i++) begin
         run_cycle(i == 1, i == 0, OPC_RET, 0, obs, exp, mask);
         if (mem_wr === 1'b1) wr_seen++;
         vectors++;
         if ((obs & mask) !== (exp & mask)) begin
            miscompares++; $display("FAIL int_during_ret c%0d: got %b want %b", i, obs, exp);
         end
      end
      vectors++;
      if (wr_seen != wr_want) begin
         miscompares++; $display("FAIL int_during_ret_pushes: got %0d want %0d", wr_seen, wr_want);
      end
   endtask

   task automatic test_int_vs_call();
      logic [VW-1:0] obs, exp, mask;
      for (int i = 0; i < 5; i++) begin
         run_cycle(i == 0, i == 0, OPC_CALL, 0, obs, exp, mask);
         vectors++;
         if ((obs & mask) !== (exp & mask)) begin
            miscompares++; $display("FAIL int_vs_call c%0d: got %b want %b", i, obs, exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [VW-1:0] obs, exp, mask;
      for (int i = 0; i < 8; i++) begin
         run_cycle(0, i == 0 || i == 4, (i == 0) ? OPC_RET : OPC_CALL, 0, obs, exp, mask);
         vectors++;
         if ((obs & mask) !== (exp & mask)) begin
            miscompares++; $display("FAIL back_to_back c%0d: got %b want %b", i, obs, exp);
         end
      end
   endtask

   task automatic test_random();
      logic [VW-1:0] obs, exp, mask;
      logic [5:0] op;
      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 3))
            0: op = OPC_CALL;
            1: op = OPC_RET;
            2: op = OPC_RETI;
            default: op = 6'($urandom);
         endcase
         run_cycle($urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0, op,
                   $urandom_range(0, 4) == 0, obs, exp, mask);
         vectors++;
         if ((obs & mask) !== (exp & mask)) begin
            miscompares++; $display("FAIL random c%0d: got %b want %b", i, obs, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_ret();
      test_int();
      test_reti();
      test_call_stall();
      test_int_during_ret();
      test_int_vs_call();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
